tff_bank_ctrl: RTL

Sequencing controller for a bank of `tff` storage cells. It accepts single-bit write, read and clear commands on a valid/ready request port, then generates the per-cell reset, write-enable and read-enable strobe sequences the cells require. It sits between the host-side register logic and the `tff` array, and is the only driver of the cells' `WE`, `RE` and `rstb` pins. Every cell strobe is registered; only one cell is strobed at a time.

---
 rtl/tff_bank_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/tff_bank_ctrl.sv
// rtl/tff_bank_ctrl.sv - strobe sequencer for a bank of tff cells; optional read-back verify via TFF_BANK_CTRL_VERIFY_EN
module tff_bank_ctrl #(
   parameter int NCELLS     = 8,
   parameter int AW         = 3,
   parameter int CLR_CYCLES = 1,
   parameter int WE_PULSE   = 2,
   parameter int RE_CYCLES  = 5
) (
   input  logic              clk,
   input  logic              rstb,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [AW-1:0]     req_addr,
   input  logic              req_data,
   output logic              rsp_valid,
   output logic              rsp_data,
   output logic              rsp_err,
   output logic [NCELLS-1:0] cell_rstb,
   output logic [NCELLS-1:0] cell_we,
   output logic [NCELLS-1:0] cell_re,
   input  logic [NCELLS-1:0] cell_out
);

   typedef enum logic [2:0] {
      S_IDLE, S_CLR, S_GAP1, S_WE, S_GAP2, S_RD, S_RSP
   } state_t;

   // Command encoding: 00 nop, 01 write, 10 read, 11 clear.
   localparam logic [1:0] OP_NOP = 2'b00;
   localparam logic [1:0] OP_WR  = 2'b01;
   localparam logic [1:0] OP_RD  = 2'b10;

   // One bit wider than the address so NCELLS itself is representable.
   localparam logic [AW:0] LIMIT = (AW+1)'(NCELLS);

   state_t            state;
   logic [7:0]        cnt;
   logic [1:0]        op_q;
   logic [AW-1:0]     addr_q;
   logic              data_q;
   logic [NCELLS-1:0] req_sel;
   logic [NCELLS-1:0] addr_sel;
   logic              rd_bit;
   logic              accept;
   logic              addr_bad;

   assign accept   = req_valid && req_ready && (req_op != OP_NOP);
   assign addr_bad = ({1'b0, req_addr} >= LIMIT);
   assign rd_bit   = |(cell_out & addr_sel);

   // One-hot cell selects for the incoming and the latched address.
   always_comb begin
      req_sel  = '0;
      addr_sel = '0;
      for (int i = 0; i < NCELLS; i++) begin
         req_sel[i]  = ({1'b0, req_addr} == (AW+1)'(i));
         addr_sel[i] = ({1'b0, addr_q}   == (AW+1)'(i));
      end
   end

   // Sequencer: every output is registered for the state being entered.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state     <= S_IDLE;
         cnt       <= '0;
         op_q      <= OP_NOP;
         addr_q    <= '0;
         data_q    <= 1'b0;
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data  <= 1'b0;
         rsp_err   <= 1'b0;
         cell_rstb <= '0;
         cell_we   <= '0;
         cell_re   <= '0;
      end else begin
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         cell_rstb <= '1;
         cell_we   <= '0;
         cell_re   <= '0;
         case (state)
            S_IDLE: begin
               req_ready <= 1'b1;
               if (accept) begin
                  op_q      <= req_op;
                  addr_q    <= req_addr;
                  data_q    <= req_data;
                  cnt       <= '0;
                  req_ready <= 1'b0;
                  if (addr_bad) begin
                     state     <= S_RSP;
                     rsp_valid <= 1'b1;
                     rsp_data  <= 1'b0;
                     rsp_err   <= 1'b1;
                  end else if (req_op == OP_RD) begin
                     state   <= S_RD;
                     cell_re <= req_sel;
                  end else begin
                     state     <= S_CLR;
                     cell_rstb <= ~req_sel;
                  end
               end
            end
            S_CLR: begin
               if (cnt == 8'(CLR_CYCLES - 1)) begin
                  state <= S_GAP1;
               end else begin
                  cnt       <= cnt + 8'd1;
                  cell_rstb <= ~addr_sel;
               end
            end
            S_GAP1, S_GAP2: begin
               cnt <= '0;
               if (state == S_GAP1 && op_q == OP_WR && data_q) begin
                  state   <= S_WE;
                  cell_we <= addr_sel;
               end else begin
`ifdef TFF_BANK_CTRL_VERIFY_EN
                  state   <= S_RD;
                  cell_re <= addr_sel;
`else
                  state     <= S_IDLE;
                  req_ready <= 1'b1;
`endif
               end
            end
            S_WE: begin
               if (cnt == 8'(WE_PULSE - 1)) begin
                  state <= S_GAP2;
               end else begin
                  cnt     <= cnt + 8'd1;
                  cell_we <= addr_sel;
               end
            end
            S_RD: begin
               if (cnt == 8'(RE_CYCLES - 1)) begin
                  state     <= S_RSP;
                  rsp_valid <= 1'b1;
                  rsp_data  <= rd_bit;
`ifdef TFF_BANK_CTRL_VERIFY_EN
                  // Expected read-back is the write data, or 0 after a clear.
                  if (op_q != OP_RD)
                     rsp_err <= (rd_bit != (op_q == OP_WR && data_q));
`endif
               end else begin
                  cnt     <= cnt + 8'd1;
                  cell_re <= addr_sel;
               end
            end
            S_RSP: begin
               state     <= S_IDLE;
               req_ready <= 1'b1;
            end
            default: begin
               state     <= S_IDLE;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule
